// File: rtl/win_ctrl_pkg.sv
// Shared types for the window shift controller.
// Holds the FSM state encoding and the counter-width helper.
package win_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_DONE
  } state_t;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-MOD up counter with clear priority.
// wrap pulses on an enabled count from MOD-1 back to 0.
module mod_counter
  import win_ctrl_pkg::*;
#(
  parameter int MOD = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  clr,
  output logic [cnt_w(MOD)-1:0] cnt,
  output logic                  wrap
);

  localparam int W = cnt_w(MOD);
  localparam logic [W-1:0] LAST = W'(MOD - 1);

  assign wrap = en && (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= wrap ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/window_shift_ctrl.sv
// Window shift controller: sequences line-buffer shifts, flags stride-aligned KxK windows.
// Define WIN_CTRL_STATS_EN to add win_cnt (windows consumed this frame).
module window_shift_ctrl
  import win_ctrl_pkg::*;
#(
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int K      = 3,
  parameter int STRIDE = 1
) (
  input  logic                    clk,
  input  logic                    global_rst,
  input  logic                    start,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic                    sr_ce,
  output logic                    sr_clr,
  output logic                    win_valid,
  input  logic                    win_ready,
  output logic [cnt_w(IMG_W)-1:0] col_cnt,
  output logic [cnt_w(IMG_H)-1:0] row_cnt,
  output logic                    busy,
  output logic                    frame_done
`ifdef WIN_CTRL_STATS_EN
  ,
  output logic [15:0]             win_cnt
`endif
);

  localparam int CW = cnt_w(IMG_W);
  localparam int RW = cnt_w(IMG_H);
  localparam int PW = cnt_w(STRIDE);
  localparam logic [CW-1:0] COL0 = CW'(K - 1);
  localparam logic [RW-1:0] ROW0 = RW'(K - 1);

  state_t state, state_nx;

  logic          clr_st;
  logic          accept;
  logic          col_wrap, row_wrap;
  logic          cph_wrap, rph_wrap;
  logic          unused_wraps;
  logic          col_ge, row_ge;
  logic          win_set;
  logic [PW-1:0] cph, rph;

  assign busy     = (state != S_IDLE);
  assign in_ready = (state == S_RUN) && !(win_valid && !win_ready);
  assign accept   = in_valid && in_ready;
  assign col_ge   = (col_cnt >= COL0);
  assign row_ge   = (row_cnt >= ROW0);
  assign win_set  = accept && col_ge && row_ge
                 && (cph == '0) && (rph == '0);
  assign unused_wraps = cph_wrap ^ rph_wrap;

  always_ff @(posedge clk or posedge global_rst) begin
    if (global_rst) state <= S_IDLE;
    else            state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    sr_ce      = 1'b0;
    sr_clr     = 1'b0;
    clr_st     = 1'b0;
    frame_done = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) state_nx = S_CLEAR;
      end
      S_CLEAR: begin
        sr_ce    = 1'b1;
        sr_clr   = 1'b1;
        clr_st   = 1'b1;
        state_nx = S_RUN;
      end
      S_RUN: begin
        sr_ce = accept;
        if (accept && col_wrap && row_wrap) state_nx = S_DONE;
      end
      S_DONE: begin
        // fire once no window is left waiting after this edge
        if (!win_valid || win_ready) begin
          frame_done = 1'b1;
          state_nx   = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  mod_counter #(.MOD(IMG_W)) u_col (
    .clk  (clk),
    .rst  (global_rst),
    .en   (accept),
    .clr  (clr_st),
    .cnt  (col_cnt),
    .wrap (col_wrap)
  );

  mod_counter #(.MOD(IMG_H)) u_row (
    .clk  (clk),
    .rst  (global_rst),
    .en   (accept && col_wrap),
    .clr  (clr_st),
    .cnt  (row_cnt),
    .wrap (row_wrap)
  );

  // phases measure distance from the first window origin, mod STRIDE
  mod_counter #(.MOD(STRIDE)) u_cph (
    .clk  (clk),
    .rst  (global_rst),
    .en   (accept && col_ge),
    .clr  (clr_st || col_wrap),
    .cnt  (cph),
    .wrap (cph_wrap)
  );

  mod_counter #(.MOD(STRIDE)) u_rph (
    .clk  (clk),
    .rst  (global_rst),
    .en   (accept && col_wrap && row_ge),
    .clr  (clr_st || row_wrap),
    .cnt  (rph),
    .wrap (rph_wrap)
  );

  always_ff @(posedge clk or posedge global_rst) begin
    if (global_rst)   win_valid <= 1'b0;
    else if (clr_st)  win_valid <= 1'b0;
    else if (win_set) win_valid <= 1'b1;
    else if (win_ready) win_valid <= 1'b0;
  end

`ifdef WIN_CTRL_STATS_EN
  always_ff @(posedge clk or posedge global_rst) begin
    if (global_rst) begin
      win_cnt <= '0;
    end else if (clr_st) begin
      win_cnt <= '0;
    end else if (win_valid && win_ready && (win_cnt != 16'hFFFF)) begin
      win_cnt <= win_cnt + 16'd1;
    end
  end
`endif

endmodule
